// File: rtl/keypad_event_queue.sv
// Keypad front end: synchronise and debounce the select button, map the cursor
// position to a key code, generate hold-to-repeat events and queue them in a FWFT FIFO.
module keypad_event_queue #(
    parameter int COLS          = 4,
    parameter int ROWS          = 4,
    parameter logic [ROWS*COLS*8-1:0] KEYMAP = {"123+456-789*C0=", 8'h00},
    parameter int DEBOUNCE_CYC  = 200000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             btn_n,
    input  logic [3:0]                       cursor_x,
    input  logic [3:0]                       cursor_y,
    output logic [7:0]                       key_code,
    output logic                             key_repeat,
    output logic                             key_valid,
    input  logic                             key_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    input  logic                             ovf_clr,
    output logic                             invalid_pulse
);

    localparam int DBW  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [DBW-1:0] DB_LAST      = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0]  RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0]  DEPTH_C      = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // ---------------- synchroniser and debounce ----------------
    logic           sync1, sync2;
    logic           db_state, db_prev;
    logic [DBW-1:0] db_cnt;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // update together from pre-edge values; blocking here would chain the synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_state <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            db_prev <= db_state;
            if (sync2 != db_state) begin
                if (db_cnt == DB_LAST) begin
                    db_state <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    logic press_det, release_det;
    assign press_det   = db_prev & ~db_state;
    assign release_det = ~db_prev & db_state;

    // ---------------- key map lookup ----------------
    logic       in_range;
    logic [7:0] map_code;
    logic       key_ok;
    int         map_idx;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        in_range = (int'(cursor_x) < COLS) && (int'(cursor_y) < ROWS);
        map_idx  = int'(cursor_y) * COLS + int'(cursor_x);
        map_code = 8'h00;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (in_range && (i == map_idx))
                map_code = KEYMAP[(ROWS*COLS-1-i)*8 +: 8];
        end
    end

    assign key_ok = in_range && (map_code != 8'h00);

    // ---------------- press / repeat FSM ----------------
    logic [1:0]    state;
    logic [RW-1:0] rpt_cnt;
    logic [7:0]    code_q;
    logic          push_req, push_rep, invalid_det;
    logic [7:0]    push_code;

    always_comb begin
        push_req    = 1'b0;
        push_rep    = 1'b0;
        push_code   = code_q;
        invalid_det = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_det) begin
                    if (key_ok) begin
                        push_req  = 1'b1;
                        push_code = map_code;
                    end else begin
                        invalid_det = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!release_det && (REPEAT_EN != 0) && (rpt_cnt == RPT_DLY_LAST)) begin
                    push_req = 1'b1;
                    push_rep = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!release_det && (rpt_cnt == RPT_PER_LAST)) begin
                    push_req = 1'b1;
                    push_rep = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rpt_cnt       <= '0;
            code_q        <= 8'h00;
            invalid_pulse <= 1'b0;
        end else begin
            invalid_pulse <= invalid_det;
            case (state)
                ST_IDLE: begin
                    rpt_cnt <= '0;
                    if (press_det && key_ok) begin
                        state  <= ST_HELD;
                        code_q <= map_code;
                    end
                end
                ST_HELD: begin
                    if (release_det) begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rpt_cnt == RPT_DLY_LAST) begin
                            state   <= ST_REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (release_det) begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == RPT_PER_LAST) begin
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

    // ---------------- event FIFO (first-word-fall-through) ----------------
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, do_push;

    assign key_valid  = (count != '0);
    assign full       = (count == DEPTH_C);
    assign pop        = key_valid & key_ready;
    assign do_push    = push_req & (~full | pop);
    assign fifo_count = count;
    assign key_code   = key_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign key_repeat = key_valid & mem[rd_ptr][8];

    // NOTE: the storage array has no reset; stale contents are never visible
    // because the outputs are gated by key_valid, which comes from the reset count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {push_rep, push_code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear wins, so no lost event goes unreported.
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
